// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One extra count so the counter can represent WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// Single-bit full adder: the one arithmetic cell that the serial adder
// iterates LSB-first.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor. One full-adder cell processes one bit
// per clock; sum, carry-out and signed overflow are registered on completion.
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;
  logic             r_ovf;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_res_next;

  fa_cell u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  // New sum bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_s;
    end else begin : g_res_wn
      assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          // On the last bit r_carry is the carry into the MSB.
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_res_next;
            r_co    <= w_c;
            r_ovf   <= r_carry ^ w_c;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: a WIDTH=1 instance for the full-adder
// truth table and a WIDTH=8 instance for arithmetic, timing and control cases.
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, co1, ovf1;
  logic [0:0] sum1;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ovf8;
  logic [7:0] sum8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1)
  );

  serial_adder_n #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; start is sampled at the following posedge (E0).
  task automatic drive8(input logic s, input logic [7:0] x, input logic [7:0] y);
    start8 = 1'b1; sub8 = s; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Counts cycles from the start cycle until done is seen at a negedge.
  // Optionally injects a stray start mid-run and checks sum is held.
  task automatic wait_done8(input logic inject, input logic [7:0] prev_sum,
                            output int n, output int nbusy);
    n = 1; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) return;
      if (busy8) nbusy++;
      if (n == 4) check("sum_held_in_run", 32'(sum8), 32'(prev_sum));
      if (inject && n == 3) begin
        start8 = 1'b1; sub8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk);
      n++;
    end
    check("done_timeout", 32'(n), 32'd9);
  endtask

  task automatic op8(input string tag, input logic s, input logic [7:0] x,
                     input logic [7:0] y, input logic [7:0] es, input logic ec,
                     input logic eo, input logic [7:0] prev_sum, input logic inject);
    int n, nb;
    drive8(s, x, y);
    wait_done8(inject, prev_sum, n, nb);
    check({tag, "_lat"}, 32'(n), 32'd9);
    check({tag, "_busy"}, 32'(nb), 32'd8);
    check({tag, "_sum"}, 32'(sum8), 32'(es));
    check({tag, "_co"}, 32'(co8), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    $display("op %s sub=%0d a=%02h b=%02h -> sum=%02h co=%0d ovf=%0d lat=%0d",
             tag, s, x, y, sum8, co8, ovf8, n);
  endtask

  initial begin
    int n, ndone;
    logic s, x, y, bb, es, ec;

    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_co_ovf", 32'({co8, ovf8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=1: full-adder truth table with carry-in = sub and b inverted on sub.
    for (int i = 0; i < 8; i++) begin
      s = i[2]; x = i[1]; y = i[0];
      bb = y ^ s;
      es = x ^ bb ^ s;
      ec = (x & bb) | (x & s) | (bb & s);
      start1 = 1'b1; sub1 = s; a1 = x; b1 = y;
      @(posedge clk); #1;
      start1 = 1'b0;
      n = 1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done1) break;
        @(posedge clk);
        n++;
      end
      check("w1_lat", 32'(n), 32'd2);
      check("w1_sum", 32'(sum1), 32'(es));
      check("w1_co", 32'(co1), 32'(ec));
      $display("w1 sub=%0d a=%0d b=%0d -> sum=%0d co=%0d lat=%0d", s, x, y, sum1, co1, n);
      @(negedge clk);
    end

    // WIDTH=8 arithmetic
    op8("add_3c_0f", 1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 8'h4B, 1'b0);
    @(negedge clk);
    op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    op8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 8'h80, 1'b0);
    @(negedge clk);
    op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 8'hFE, 1'b0);
    @(negedge clk);

    // Stray start mid-run must be ignored.
    op8("midrun_ign", 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 8'h7F, 1'b1);
    @(negedge clk);
    check("midrun_idle_after", 32'(busy8), 32'd0);
    @(negedge clk);

    // Back-to-back: second start issued during the done cycle.
    op8("b2b_first", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 8'h46, 1'b0);
    op8("b2b_second", 1'b1, 8'h50, 8'h10, 8'h40, 1'b1, 1'b0, 8'h30, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-run.
    drive8(1'b0, 8'h01, 8'h01);
    @(negedge clk); @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy8), 32'd0);
    check("arst_done", 32'(done8), 32'd0);
    check("arst_sum", 32'(sum8), 32'd0);
    check("arst_co_ovf", 32'({co8, ovf8}), 32'd0);
    $display("async reset mid-run: busy=%0d done=%0d sum=%02h", busy8, done8, sum8);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("arst_no_done", 32'(ndone), 32'd0);
    op8("after_rst", 1'b0, 8'h21, 8'h21, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder/subtractor: the sequential, multi-bit successor to the single-bit full-adder cells. The block accepts two WIDTH-bit operands on a start strobe and iterates one full-adder cell LSB-first, one bit per clock. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It serves as the area-minimal arithmetic unit for the lab datapaths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly one cycle, while in DONE.
- sum  out  WIDTH  registered result of the last completed operation.
- co  out  1  carry-out of the MSB; for subtraction, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE
  - start=1 → RUN.
  - Load shift register A ← a and B ← (sub ? ~b : b).
  - carry ← sub, bit counter ← 0.
- RUN, each cycle
  - Full-adder cell computes s,c from A[0], B[0], carry.
  - A and B shift right; s shifts into the MSB of the result shift register.
  - carry ← c, counter increments.
  - The carry into the MSB (the carry before the final bit) is captured for ovf.
  - When counter = WIDTH−1 this cycle processes the last bit → DONE.
  - At that same edge, sum, co and ovf are copied from the shift register and final carry.
- DONE
  - done=1 for this one cycle.
  - start=1 → RUN with a fresh load (back-to-back operation); done still pulses this cycle.
  - Otherwise → IDLE.
- start in RUN is ignored; the operation in flight is unaffected.
- sum, co and ovf hold their previous values through RUN and change only at the completing edge.
- Arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH+1) bits wide.
- WIDTH=1 degenerates to a registered single full adder with carry-in = sub.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, co 0, ovf 0, all internal registers 0.
- Reset is asynchronous and takes effect immediately, including mid-RUN; the operation in flight is discarded with no done pulse.
- Latency: start sampled at edge E0 → busy high from E0 through edge E_WIDTH.
- sum, co and ovf are valid and done=1 in the cycle after E_WIDTH, i.e. WIDTH+1 cycles after start is sampled.
- Throughput with back-to-back start in DONE: one result per WIDTH+1 cycles.
- No combinational path from any input to any output.

## Structure
- Package serial_adder_pkg:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - function cnt_w(WIDTH) returning the counter width.
- Sub-module fa_cell (a, b, ci → s, co), purely combinational: s = a^b^ci, co = majority(a,b,ci).
- Top level contains the FSM, operand and result shift registers, carry flop, counter and output registers.

## Test plan
- WIDTH=1, all 8 combinations of {sub,a,b} → sum/co match the full-adder truth table with ci=sub; done arrives 2 cycles after start.
- WIDTH=8, 8'h3C+8'h0F → sum 8'h4B, co 0, ovf 0; done exactly 9 cycles after start; busy high for 8 cycles.
- WIDTH=8, 8'hFF+8'h01 → sum 8'h00, co 1, ovf 0. Then 8'h7F+8'h01 → sum 8'h80, co 0, ovf 1.
- WIDTH=8 subtraction:
  - 8'h05−8'h07 → sum 8'hFE, co 0, ovf 0.
  - 8'h80−8'h01 → sum 8'h7F, co 1, ovf 1.
- Control and reset, WIDTH=8:
  - Pulse start in mid-RUN with different operands → ignored; the original result is returned.
  - Assert start in the DONE cycle → second result arrives 9 cycles later; done pulses twice.
  - Assert rst_n=0 mid-RUN → all outputs 0 immediately, no done pulse; a fresh start afterwards completes normally.
